// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: turns CMD/ADDR/[DATA] frames from a UART into
// register read/write strobes and sends a one-byte response back.
module uart_cmd_parser #(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] ACK_BYTE    = 8'h55,
  parameter logic [7:0] NAK_BYTE    = 8'hEE
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  localparam logic [7:0] CMD_WR = 8'hA1;
  localparam logic [7:0] CMD_RD = 8'hA2;

  localparam int            CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic          rd_wait_q, rd_wait_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          reg_wr_q, reg_wr_d;
  logic          reg_rd_q, reg_rd_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_q, err_d;
  logic          err_inc_s;

  // Next-state, strobe and error-event decode.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    rd_wait_d   = 1'b0;
    to_cnt_d    = {CW{1'b0}};
    tx_data_d   = tx_data_q;
    tx_wr_d     = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    err_inc_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
            is_wr_d = (rx_data == CMD_WR);
            state_d = S_ADDR;
          end else begin
            tx_data_d = NAK_BYTE;
            tx_wr_d   = 1'b1;
            err_inc_s = 1'b1;
            state_d   = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR, S_DATA: begin
        // An arriving byte always beats a simultaneous timeout expiry.
        if (rx_done) begin
          if (state_q == S_ADDR) begin
            reg_addr_d = rx_data;
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              reg_rd_d = 1'b1;
              state_d  = S_EXEC;
            end
          end else begin
            reg_wdata_d = rx_data;
            reg_wr_d    = 1'b1;
            state_d     = S_EXEC;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_inc_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        err_inc_s = rx_done;
        if (is_wr_q) begin
          tx_data_d = ACK_BYTE;
          tx_wr_d   = 1'b1;
          state_d   = S_RESP;
        end else if (rd_wait_q) begin
          tx_data_d = reg_rdata;
          tx_wr_d   = 1'b1;
          state_d   = S_RESP;
        end else begin
          rd_wait_d = 1'b1;
        end
      end
      S_RESP: begin
        err_inc_s = rx_done;
        state_d   = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        err_inc_s = rx_done;
        if (tx_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_TX;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    if (err_inc_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      rd_wait_q   <= 1'b0;
      to_cnt_q    <= {CW{1'b0}};
      tx_data_q   <= 8'h00;
      tx_wr_q     <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      rd_wait_q   <= rd_wait_d;
      to_cnt_q    <= to_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_wr_q     <= tx_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;
  assign err_cnt   = err_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: inter-byte timeout in sys_clk cycles.
REQ-002 Parameter ACK_BYTE, default 8'h55: response byte for a completed write.
REQ-003 Parameter NAK_BYTE, default 8'hEE: response byte for an unknown command.
REQ-004 sys_clk  in  1: single clock; all logic rising-edge.
REQ-005 sys_rst  in  1: asynchronous, active-high reset.
REQ-006 rx_data  in  8: received byte from the UART transceiver, valid when rx_done=1.
REQ-007 rx_done  in  1: one-cycle pulse per received byte.
REQ-008 tx_data  out 8: byte to transmit, held stable from the tx_wr pulse until tx_done.
REQ-009 tx_wr  out 1: one-cycle transmit request.
REQ-010 tx_done  in  1: one-cycle pulse when the transceiver finishes a byte.
REQ-011 reg_addr  out 8: register address, held until the next command.
REQ-012 reg_wdata  out 8: register write data, held until the next command.
REQ-013 reg_wr  out 1: one-cycle register write strobe.
REQ-014 reg_rd  out 1: one-cycle register read strobe.
REQ-015 reg_rdata  in  8: read data, valid the cycle after reg_rd.
REQ-016 busy  out 1: high in every state except IDLE.
REQ-017 err_cnt  out 8: count of protocol errors, saturating at 8'hFF.

Function
REQ-018 Frame format: CMD, ADDR, then DATA only when CMD is write; CMD 8'hA1 = write, 8'hA2 = read, any other value = unknown.
REQ-019 FSM states: IDLE, ADDR, DATA, EXEC, RESP, WAIT_TX.
REQ-020 IDLE + rx_done: latch rx_data as the command; A1/A2 -> ADDR; unknown -> RESP with tx_data=NAK_BYTE and err_cnt+1.
REQ-021 ADDR + rx_done: reg_addr<=rx_data; write -> DATA; read -> EXEC.
REQ-022 DATA + rx_done: reg_wdata<=rx_data, then -> EXEC.
REQ-023 EXEC, write: reg_wr=1 for exactly the one cycle following the final byte's rx_done, tx_data<=ACK_BYTE, then -> RESP.
REQ-024 EXEC, read: reg_rd=1 for one cycle; next cycle tx_data<=reg_rdata, then -> RESP.
REQ-025 RESP: tx_wr=1 for one cycle, then -> WAIT_TX.
REQ-026 WAIT_TX: on tx_done -> IDLE; tx_data stays unchanged while waiting.
REQ-027 Latency from the final byte's rx_done to tx_wr: 2 cycles for a write, 3 cycles for a read.
REQ-028 Timeout counter: cleared on each rx_done and counts in ADDR/DATA only.
REQ-029 Timeout: when the counter reaches TIMEOUT_CYC-1 -> IDLE with no reg_wr, no response, err_cnt+1.
REQ-030 rx_done in EXEC/RESP/WAIT_TX: byte dropped, err_cnt+1, state unaffected.
REQ-031 rx_done and timeout expiry in the same cycle: the byte wins, no timeout.
REQ-032 err_cnt increments at most once per cycle and holds at 8'hFF.
REQ-033 reg_wr and reg_rd are never asserted together; tx_wr never reasserts before tx_done.

Reset
REQ-034 While sys_rst=1: state=IDLE; tx_wr, reg_wr, reg_rd, busy = 0; tx_data, reg_addr, reg_wdata, err_cnt = 8'h00; timeout counter = 0.
REQ-035 Reset mid-frame or mid-transmit aborts immediately, with no strobe emitted after sys_rst rises.
REQ-036 The first frame after sys_rst falls is parsed normally.

Verification
REQ-037 Bytes A1,10,5A -> one reg_wr pulse with reg_addr=10, reg_wdata=5A; tx_wr 2 cycles later with tx_data=55; busy drops after tx_done.
REQ-038 Bytes A2,03 with reg_rdata=C3 -> reg_rd pulse with reg_addr=03; tx_data=C3; tx_wr 3 cycles after the second rx_done.
REQ-039 Byte 7F -> tx_data=EE, err_cnt=1, no reg_wr/reg_rd; next frame A1,00,01 completes normally.
REQ-040 A1,20 then silence for TIMEOUT_CYC cycles -> IDLE, err_cnt+1, no reg_wr, no tx_wr.
REQ-041 Extra byte sent during WAIT_TX -> byte dropped, err_cnt+1, response unaffected.
REQ-042 sys_rst pulsed between bytes 2 and 3 of a write -> all outputs at reset values; trailing byte parsed as a new CMD.
